// File: rtl/urp_pcie_dll_pkg.sv
// rtl/urp_pcie_dll_pkg.sv - shared widths, frame layout and state type for the TX data link layer
package urp_pcie_dll_pkg;
  localparam int TLP_W   = 224;
  localparam int SEQ_W   = 12;
  localparam int LCRC_W  = 32;
  localparam int FRAME_W = 272;

  localparam logic [LCRC_W-1:0] LCRC_POLY = 32'h04C11DB7;
  localparam logic [LCRC_W-1:0] LCRC_INIT = 32'hFFFFFFFF;

  typedef struct packed {
    logic [3:0]        rsvd;
    logic [SEQ_W-1:0]  seq;
    logic [TLP_W-1:0]  tlp;
    logic [LCRC_W-1:0] lcrc;
  } dl_frame_t;

  typedef enum logic [1:0] {
    NORMAL,
    REPLAY_WAIT,
    REPLAY
  } dl_state_e;
endpackage

// File: rtl/urp_pcie_lcrc32.sv
// rtl/urp_pcie_lcrc32.sv - combinational CRC-32 over the 240-bit frame header+payload
// Bits are shifted in MSB first, no reflection, result inverted.
module urp_pcie_lcrc32
  import urp_pcie_dll_pkg::*;
(
  input  logic [FRAME_W-LCRC_W-1:0] data_i,
  output logic [LCRC_W-1:0]         lcrc_o
);
  logic [LCRC_W-1:0] crc;
  logic              fb;

  always_comb begin
    crc = LCRC_INIT;
    fb  = 1'b0;
    for (int i = FRAME_W - LCRC_W - 1; i >= 0; i--) begin
      fb  = crc[LCRC_W-1] ^ data_i[i];
      crc = {crc[LCRC_W-2:0], 1'b0} ^ (fb ? LCRC_POLY : '0);
    end
    lcrc_o = ~crc;
  end
endmodule

// File: rtl/urp_pcie_tx_data_link_layer.sv
// rtl/urp_pcie_tx_data_link_layer.sv - TX DLL: sequence/LCRC framing, retry buffer, ACK/NAK replay
// Frames are stored by seq mod RETRY_DEPTH and replayed unchanged on NAK or replay timeout.
module urp_pcie_tx_data_link_layer
  import urp_pcie_dll_pkg::*;
#(
  parameter int RETRY_DEPTH    = 8,
  parameter int REPLAY_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TLP_W-1:0]   tlp_i,
  input  logic               tlp_valid_i,
  output logic               tlp_ready_o,
  input  logic               ack_valid_i,
  input  logic               ack_nak_i,
  input  logic [SEQ_W-1:0]   ack_seq_i,
  output logic [FRAME_W-1:0] dl_frame_o,
  output logic               dl_valid_o,
  input  logic               dl_ready_i,
  output logic               replay_active_o
);
  localparam int IDX_W = $clog2(RETRY_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int TMR_W = $clog2(REPLAY_TIMEOUT + 1);

  dl_state_e          state_q;
  logic               run_q;
  logic [SEQ_W-1:0]   next_seq_q, acked_seq_q, rp_q;
  logic [CNT_W-1:0]   count_q;
  logic [TMR_W-1:0]   timer_q;
  logic [FRAME_W-1:0] frame_q;
  logic               valid_q, replay_q;
  logic [FRAME_W-1:0] mem_q [RETRY_DEPTH];

  logic [FRAME_W-LCRC_W-1:0] hdr_tlp;
  logic [LCRC_W-1:0]         lcrc;
  dl_frame_t                 new_frame;

  assign hdr_tlp = {4'b0, next_seq_q, tlp_i};

  urp_pcie_lcrc32 u_lcrc (
    .data_i (hdr_tlp),
    .lcrc_o (lcrc)
  );

  assign new_frame = '{rsvd: 4'b0, seq: next_seq_q, tlp: tlp_i, lcrc: lcrc};

  logic             out_free, out_fire, accept, ack_ok, nak_ok, timeout, replay_req;
  logic [SEQ_W-1:0] ack_diff, acked_d, oldest, rp_off, rp_eff;
  logic [CNT_W-1:0] purged, count_d;

  assign out_fire    = valid_q && dl_ready_i;
  assign out_free    = !valid_q || dl_ready_i;
  assign tlp_ready_o = run_q && (state_q == NORMAL) && (count_q < CNT_W'(RETRY_DEPTH)) && out_free;
  assign accept      = tlp_valid_i && tlp_ready_o;

  // An ACK/NAK is in range when it names an outstanding seq; a NAK may also repeat the last acked seq.
  assign ack_diff   = ack_seq_i - acked_seq_q;
  assign ack_ok     = ack_valid_i && (ack_diff != '0) && (ack_diff <= SEQ_W'(count_q));
  assign nak_ok     = ack_valid_i && ack_nak_i && (ack_diff <= SEQ_W'(count_q));
  assign purged     = ack_ok ? CNT_W'(ack_diff) : '0;
  assign acked_d    = ack_ok ? ack_seq_i : acked_seq_q;
  assign count_d    = count_q - purged + CNT_W'(accept);
  assign timeout    = (state_q == NORMAL) && (timer_q == TMR_W'(REPLAY_TIMEOUT));
  assign replay_req = (nak_ok || timeout) && (count_d != '0);

  assign oldest = acked_d + SEQ_W'(1);
  assign rp_off = rp_q - oldest;
  assign rp_eff = (nak_ok || (rp_off >= SEQ_W'(count_d))) ? oldest : rp_q;

  always_ff @(posedge clk) begin
    if (accept) mem_q[next_seq_q[IDX_W-1:0]] <= new_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NORMAL;
      run_q       <= 1'b0;
      next_seq_q  <= '0;
      acked_seq_q <= '1;
      count_q     <= '0;
      timer_q     <= '0;
      rp_q        <= '0;
      frame_q     <= '0;
      valid_q     <= 1'b0;
      replay_q    <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      acked_seq_q <= acked_d;
      count_q     <= count_d;
      if (accept) next_seq_q <= next_seq_q + SEQ_W'(1);
      if (ack_ok || timeout || (state_q != NORMAL) || (count_q == '0)) timer_q <= '0;
      else timer_q <= timer_q + TMR_W'(1);

      case (state_q)
        NORMAL: begin
          if (accept) begin
            frame_q <= new_frame;
            valid_q <= 1'b1;
          end else if (out_fire) begin
            valid_q <= 1'b0;
          end
          if (replay_req) state_q <= REPLAY_WAIT;
        end
        REPLAY_WAIT: begin
          if (out_fire) valid_q <= 1'b0;
          if (count_d == '0) begin
            state_q <= NORMAL;
          end else if (out_free) begin
            state_q  <= REPLAY;
            replay_q <= 1'b1;
            rp_q     <= oldest;
          end
        end
        REPLAY: begin
          if (count_d == '0) begin
            state_q  <= NORMAL;
            replay_q <= 1'b0;
            if (out_fire) valid_q <= 1'b0;
          end else if (out_free) begin
            frame_q <= mem_q[rp_eff[IDX_W-1:0]];
            valid_q <= 1'b1;
            rp_q    <= rp_eff + SEQ_W'(1);
            if (rp_eff == next_seq_q - SEQ_W'(1)) begin
              state_q  <= NORMAL;
              replay_q <= 1'b0;
            end
          end else begin
            rp_q <= rp_eff;
          end
        end
        default: state_q <= NORMAL;
      endcase
    end
  end

  assign dl_frame_o      = frame_q;
  assign dl_valid_o      = valid_q;
  assign replay_active_o = replay_q;
endmodule

// File: tb/tb_urp_pcie_tx_data_link_layer.sv
// tb/tb_urp_pcie_tx_data_link_layer.sv - scoreboard bench for the TX data link layer
module tb_urp_pcie_tx_data_link_layer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [223:0] tlp_i = '0;
  logic         tlp_valid_i = 1'b0;
  logic         tlp_ready_o;
  logic         ack_valid_i = 1'b0;
  logic         ack_nak_i = 1'b0;
  logic [11:0]  ack_seq_i = '0;
  logic [271:0] dl_frame_o;
  logic         dl_valid_o;
  logic         dl_ready_i = 1'b1;
  logic         replay_active_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [271:0] exp_q[$];
  logic [271:0] exp_f;
  logic [271:0] sent [4096];
  logic [11:0]  tb_seq = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  urp_pcie_tx_data_link_layer #(
    .RETRY_DEPTH    (8),
    .REPLAY_TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .tlp_i           (tlp_i),
    .tlp_valid_i     (tlp_valid_i),
    .tlp_ready_o     (tlp_ready_o),
    .ack_valid_i     (ack_valid_i),
    .ack_nak_i       (ack_nak_i),
    .ack_seq_i       (ack_seq_i),
    .dl_frame_o      (dl_frame_o),
    .dl_valid_o      (dl_valid_o),
    .dl_ready_i      (dl_ready_i),
    .replay_active_o (replay_active_o)
  );

  // Reference CRC as long division of the augmented message, init folded into the first 32 bits.
  function automatic logic [31:0] ref_lcrc(input logic [239:0] d);
    logic [271:0] m;
    m = {d, 32'h0};
    m[271:240] = m[271:240] ^ 32'hFFFFFFFF;
    for (int i = 271; i >= 32; i--)
      if (m[i]) m[i -: 33] = m[i -: 33] ^ {1'b1, 32'h04C11DB7};
    return ~m[31:0];
  endfunction

  function automatic logic [271:0] make_frame(input logic [11:0] s, input logic [223:0] t);
    logic [239:0] h;
    h = {4'h0, s, t};
    return {h, ref_lcrc(h)};
  endfunction

  always @(negedge clk) begin
    if (!rst && dl_valid_o && dl_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got seq=%0d expected no frame", dl_frame_o[267:256]);
      end else begin
        exp_f = exp_q.pop_front();
        if (dl_frame_o !== exp_f) begin
          failures++;
          $display("FAIL sb_frame got=%h expected=%h", dl_frame_o, exp_f);
        end
      end
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    tlp_valid_i = 1'b0;
    ack_valid_i = 1'b0;
    dl_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tb_seq = '0;
  endtask

  task automatic send_tlp(input logic [223:0] d);
    int n;
    n = 0;
    tlp_i = d;
    tlp_valid_i = 1'b1;
    @(negedge clk);
    while (!tlp_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!tlp_ready_o) begin
      failures++;
      $display("FAIL send_ready got=0 expected=1 seq=%0d", tb_seq);
    end else begin
      sent[tb_seq] = make_frame(tb_seq, d);
      exp_q.push_back(sent[tb_seq]);
      tb_seq = tb_seq + 12'd1;
    end
    @(posedge clk);
    #1;
    tlp_valid_i = 1'b0;
  endtask

  task automatic send_ack(input logic nak, input logic [11:0] s);
    ack_valid_i = 1'b1;
    ack_nak_i = nak;
    ack_seq_i = s;
    @(posedge clk);
    #1;
    ack_valid_i = 1'b0;
    ack_nak_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain remaining=%0d expected=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    dl_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tlp_ready_o !== 1'b0) begin failures++; $display("FAIL rst_tlp_ready got=%b expected=0", tlp_ready_o); end
    checks++; if (dl_valid_o !== 1'b0) begin failures++; $display("FAIL rst_dl_valid got=%b expected=0", dl_valid_o); end
    checks++; if (dl_frame_o !== '0) begin failures++; $display("FAIL rst_dl_frame got=%h expected=0", dl_frame_o); end
    checks++; if (replay_active_o !== 1'b0) begin failures++; $display("FAIL rst_replay got=%b expected=0", replay_active_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tb_seq = '0;
  endtask

  task automatic test_basic;
    logic [223:0] d;
    do_reset();
    d = {28{8'hA5}};
    send_tlp(d);
    checks++; if (dl_valid_o !== 1'b1) begin failures++; $display("FAIL basic_latency valid got=%b expected=1", dl_valid_o); end
    checks++; if (dl_frame_o !== make_frame(12'd0, d)) begin failures++; $display("FAIL basic_frame0 got=%h expected=%h", dl_frame_o, make_frame(12'd0, d)); end
    send_tlp(~d);
    checks++; if (dl_frame_o[267:256] !== 12'd1) begin failures++; $display("FAIL basic_seq1 got=%0d expected=1", dl_frame_o[267:256]); end
    wait_drain("basic");
    send_ack(1'b0, 12'd1);
  endtask

  task automatic test_reset_mid;
    logic [223:0] d;
    do_reset();
    dl_ready_i = 1'b0;
    send_tlp({7{$urandom()}});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (dl_valid_o !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b expected=0", dl_valid_o); end
    checks++; if (tlp_ready_o !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b expected=0", tlp_ready_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    tb_seq = '0;
    dl_ready_i = 1'b1;
    d = {7{$urandom()}};
    send_tlp(d);
    checks++; if (dl_frame_o !== make_frame(12'd0, d)) begin failures++; $display("FAIL rstmid_seq0 got seq=%0d expected=0", dl_frame_o[267:256]); end
    wait_drain("rstmid");
    send_ack(1'b0, 12'd0);
  endtask

  task automatic test_fill;
    do_reset();
    for (int i = 0; i < 8; i++) send_tlp({7{$urandom()}});
    @(negedge clk);
    checks++; if (tlp_ready_o !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b expected=0", tlp_ready_o); end
    @(posedge clk);
    #1;
    send_ack(1'b0, 12'd3);
    @(negedge clk);
    checks++; if (tlp_ready_o !== 1'b1) begin failures++; $display("FAIL fill_after_ack_ready got=%b expected=1", tlp_ready_o); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_tlp({7{$urandom()}});
    @(negedge clk);
    checks++; if (tlp_ready_o !== 1'b0) begin failures++; $display("FAIL fill_four_free_ready got=%b expected=0", tlp_ready_o); end
    @(posedge clk);
    #1;
    wait_drain("fill");
    send_ack(1'b0, tb_seq - 12'd1);
  endtask

  task automatic test_nak;
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) send_tlp({7{$urandom()}});
    wait_drain("nak_tx");
    for (int s = 3; s < 6; s++) exp_q.push_back(sent[s]);
    send_ack(1'b1, 12'd2);
    n = 0;
    while (!replay_active_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (replay_active_o !== 1'b1) begin failures++; $display("FAIL nak_replay_active got=%b expected=1", replay_active_o); end
    @(posedge clk);
    #1;
    wait_drain("nak_replay");
    checks++; if (replay_active_o !== 1'b0) begin failures++; $display("FAIL nak_replay_end got=%b expected=0", replay_active_o); end
    send_ack(1'b0, 12'd5);
    send_tlp({7{$urandom()}});
    checks++; if (dl_frame_o[267:256] !== 12'd6) begin failures++; $display("FAIL nak_next_seq got=%0d expected=6", dl_frame_o[267:256]); end
    wait_drain("nak_new");
    send_ack(1'b0, 12'd6);
  endtask

  task automatic test_timeout;
    int c0, n, dly;
    do_reset();
    send_tlp({7{$urandom()}});
    c0 = cyc;
    send_tlp({7{$urandom()}});
    wait_drain("to_tx");
    repeat (5) @(posedge clk);
    #1;
    send_ack(1'b0, 12'hFFF);
    checks++; if (replay_active_o !== 1'b0) begin failures++; $display("FAIL to_stale_ack replay got=%b expected=0", replay_active_o); end
    exp_q.push_back(sent[0]);
    exp_q.push_back(sent[1]);
    n = 0;
    while (!replay_active_o && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (replay_active_o !== 1'b1) begin
      failures++;
      $display("FAIL to_replay_start got=%b expected=1", replay_active_o);
    end else begin
      dly = cyc - c0;
      checks++;
      if (dly < 16 || dly > 20) begin failures++; $display("FAIL to_delay got=%0d expected=16..20", dly); end
    end
    @(posedge clk);
    #1;
    wait_drain("to_replay");
    send_ack(1'b0, 12'd1);
  endtask

  task automatic test_stall_replay;
    int n;
    logic [271:0] snap;
    do_reset();
    for (int i = 0; i < 6; i++) send_tlp({7{$urandom()}});
    wait_drain("stall_tx");
    for (int s = 1; s < 6; s++) exp_q.push_back(sent[s]);
    send_ack(1'b1, 12'd0);
    n = 0;
    while (exp_q.size() > 3 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    dl_ready_i = 1'b0;
    snap = dl_frame_o;
    checks++; if (replay_active_o !== 1'b1 || dl_valid_o !== 1'b1) begin failures++; $display("FAIL stall_state replay=%b valid=%b expected=1,1", replay_active_o, dl_valid_o); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (dl_frame_o !== snap || dl_valid_o !== 1'b1) begin failures++; $display("FAIL stall_hold%0d got seq=%0d valid=%b expected seq=%0d valid=1", k, dl_frame_o[267:256], dl_valid_o, snap[267:256]); end
    end
    @(posedge clk);
    #1;
    send_ack(1'b1, 12'd1);
    if (exp_q.size() != 0) snap = exp_q[0];
    exp_q.delete();
    exp_q.push_back(snap);
    for (int s = 2; s < 6; s++) exp_q.push_back(sent[s]);
    dl_ready_i = 1'b1;
    wait_drain("stall_replay");
    checks++; if (replay_active_o !== 1'b0) begin failures++; $display("FAIL stall_replay_end got=%b expected=0", replay_active_o); end
    send_ack(1'b0, 12'd5);
  endtask

  task automatic test_wrap;
    logic seen;
    do_reset();
    for (int i = 0; i < 4100; i++) begin
      send_tlp({7{$urandom()}});
      if (i == 4095 || i == 4096 || i == 4099) begin
        checks++;
        if (dl_frame_o[267:256] !== 12'(i)) begin failures++; $display("FAIL wrap_seq got=%0d expected=%0d", dl_frame_o[267:256], 12'(i)); end
      end
      if ((i + 1) % 5 == 0) send_ack(1'b0, 12'(i));
    end
    wait_drain("wrap");
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (replay_active_o) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL wrap_idle_replay got=1 expected=0"); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send_tlp({7{$urandom()}});
    @(negedge clk);
    checks++; if (tlp_ready_o !== 1'b0) begin failures++; $display("FAIL wrap_fill_ready got=%b expected=0", tlp_ready_o); end
    @(posedge clk);
    #1;
    wait_drain("wrap_fill");
    send_ack(1'b0, tb_seq - 12'd1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_fill();
    test_nak();
    test_timeout();
    test_stall_replay();
    test_wrap();
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL end_queue remaining=%0d expected=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at time %0t expected bench completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
